// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_t : transmit FSM state encoding
//   OVERSAMPLE   : baud ticks per data/start/parity bit
//   SB_1/SB_1P5/SB_2 : stop-bit lengths in baud ticks
//   cnt_width()  : counter width helper that never returns 0
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } uart_state_t;

  localparam int OVERSAMPLE = 16;

  localparam int SB_1   = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2   = 32;

  // Width able to hold 0..n-1, at least one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: free-running divisor counter 0..dvsr.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous counter clear (restarts the tick phase)
//   dvsr       : divisor; tick period is dvsr+1 clocks
//   tick       : high in the cycle the counter equals dvsr
module uart_baud_gen #(
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  output logic                  tick
);

  logic [DVSR_WIDTH-1:0] cnt_q;

  assign tick = (cnt_q == dvsr);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: pulls bytes from the TX FIFO and serializes them as
// start bit, LSB-first data, optional even parity, stop bit(s).
//   clk, reset    : clock, asynchronous active-high reset
//   dvsr          : baud divisor, latched once per frame in FETCH
//   fifo_empty    : FIFO empty flag
//   fifo_r_data   : FIFO registered read data (valid the cycle after fifo_rd)
//   fifo_rd       : FIFO read strobe, one cycle per byte
//   tx            : registered serial line, idle high
//   tx_busy       : high from FETCH through the end of the stop bit
//   tx_done_tick  : one-cycle pulse in the last cycle of the stop bit
//
// FIFO handshake: fifo_rd is a request that is only raised in IDLE while
// fifo_empty is low, so every strobe is honoured; the byte it returns is
// consumed exactly one cycle later in FETCH.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_EN  = 0,
  parameter int DVSR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DVSR_WIDTH-1:0] dvsr,
  input  logic                  fifo_empty,
  input  logic [DATA_BITS-1:0]  fifo_r_data,
  output logic                  fifo_rd,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done_tick
);

  localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
  localparam int S_W   = cnt_width(S_MAX);
  localparam int N_W   = cnt_width(DATA_BITS);

  localparam logic [S_W-1:0] OS_LAST = S_W'(OVERSAMPLE - 1);
  localparam logic [S_W-1:0] SB_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST  = N_W'(DATA_BITS - 1);

  uart_state_t           state_q, state_next;
  logic [S_W-1:0]        s_q, s_next;
  logic [N_W-1:0]        n_q, n_next;
  logic [DATA_BITS-1:0]  sreg_q, sreg_next;
  logic                  parity_q, parity_next;
  logic [DVSR_WIDTH-1:0] dvsr_q, dvsr_next;
  logic                  tx_q, tx_next;
  logic                  rd_req;
  logic                  done;
  logic                  baud_clear;
  logic                  tick;

  uart_baud_gen #(
    .DVSR_WIDTH(DVSR_WIDTH)
  ) u_baud_gen (
    .clk   (clk),
    .reset (reset),
    .clear (baud_clear),
    .dvsr  (dvsr_q),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      s_q      <= '0;
      n_q      <= '0;
      sreg_q   <= '0;
      parity_q <= 1'b0;
      dvsr_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_next;
      s_q      <= s_next;
      n_q      <= n_next;
      sreg_q   <= sreg_next;
      parity_q <= parity_next;
      dvsr_q   <= dvsr_next;
      tx_q     <= tx_next;
    end
  end

  always_comb begin
    state_next  = state_q;
    s_next      = s_q;
    n_next      = n_q;
    sreg_next   = sreg_q;
    parity_next = parity_q;
    dvsr_next   = dvsr_q;
    rd_req      = 1'b0;
    done        = 1'b0;
    baud_clear  = 1'b0;
    tx_next     = 1'b1;

    case (state_q)
      ST_IDLE: begin
        baud_clear = 1'b1;
        if (!fifo_empty) begin
          rd_req     = 1'b1;
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        // Clearing the divisor here makes the start bit begin on a fresh
        // tick phase with the newly latched divisor.
        baud_clear  = 1'b1;
        sreg_next   = fifo_r_data;
        dvsr_next   = dvsr;
        parity_next = ^fifo_r_data;
        state_next  = ST_START;
      end

      ST_START: begin
        if (tick) begin
          if (s_q == OS_LAST) state_next = ST_DATA;
          else                s_next = s_q + 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            sreg_next = sreg_q >> 1;
            s_next    = '0;
            if (n_q == N_LAST) begin
              state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
            end else begin
              n_next = n_q + 1'b1;
            end
          end else begin
            s_next = s_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (s_q == OS_LAST) state_next = ST_STOP;
          else                s_next = s_q + 1'b1;
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            done       = 1'b1;
            state_next = ST_IDLE;
          end else begin
            s_next = s_q + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Tick and bit counters restart at every state change.
    if (state_next != state_q) begin
      s_next = '0;
      n_next = '0;
    end

    // The line is registered, so it is driven from the state being entered;
    // after a shift, bit 0 already holds the bit of the next bit period.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = sreg_next[0];
      ST_PARITY: tx_next = parity_q;
      default:   tx_next = 1'b1;
    endcase
  end

  // State is IDLE throughout reset, so the read request is masked to keep
  // the FIFO untouched while reset is held.
  assign fifo_rd      = rd_req & ~reset;
  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done;

endmodule
